prf_ram_mp: RTL and testbench
=============================

Name: prf_ram_mp

Overview:
- Next-generation physical register file RAM, parametrised in read-port count, write-port count, depth, width and read latency.
- Adds what the previous PRF array lacks: hardware initialisation after reset or on request, deterministic multi-write conflict resolution, and optional write-to-read bypass.
- Sits between register read / writeback and the issue-width-scaled datapath.
- Read and write ports are packed vectors, so port counts are not limited by compile-time defines.

Parameters:
- RPORT, 8, number of read ports (1..16).
- WPORT, 4, number of write ports (1..8).
- DEPTH, 16, number of entries (power of two, ≥2).
- INDEX, 4, address width; must equal log2(DEPTH).
- WIDTH, 8, data width per entry.
- READ_REG, 0, 0 = combinational read, 1 = registered read (1-cycle latency).
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read.
- INIT_VAL, 0, value loaded into every entry during initialisation (WIDTH bits).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- clear_i  in  1  request re-initialisation; sampled only in READY.
- raddr_i  in  RPORT*INDEX  read addresses; port p at [p*INDEX +: INDEX].
- rdata_o  out  RPORT*WIDTH  read data; port p at [p*WIDTH +: WIDTH].
- waddr_i  in  WPORT*INDEX  write addresses.
- wdata_i  in  WPORT*WIDTH  write data.
- we_i  in  WPORT  write enables, one per port.
- init_done_o  out  1  high in READY state.
- wr_conflict_o  out  1  registered; high one cycle after two or more enabled writes target the same address.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FSM → CLEAR, clr_idx=0, init_done_o=0, wr_conflict_o=0.
  - Registered rdata_o (READ_REG=1) = 0.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: each cycle writes INIT_VAL to ram[clr_idx] and increments clr_idx. At clr_idx=DEPTH-1 the write completes and the FSM moves to READY next cycle. CLEAR always lasts exactly DEPTH cycles after reset deassertion.
  - READY: init_done_o=1. clear_i=1 → CLEAR with clr_idx=0 on the next edge; that same-cycle user writes are still performed.
- In CLEAR:
  - we_i ignored; no user writes occur.
  - rdata_o forced to 0 (combinational output for READ_REG=0; register loads 0 for READ_REG=1).
  - clear_i ignored.
  - wr_conflict_o held 0.
- Reset asserted mid-CLEAR restarts from index 0.
- Writes (READY): on posedge, for each port w with we_i[w]=1, ram[waddr_w] ← wdata_w.
  - If several enabled ports share an address, the highest-numbered port wins.
  - wr_conflict_o=1 on the following cycle only; no sticky state.
- Reads, READ_REG=0: rdata_p = ram[raddr_p] combinationally.
  - With BYPASS=1, if any enabled write port matches raddr_p in the same cycle, the highest-numbered matching port's wdata is returned instead.
- Reads, READ_REG=1: rdata_p registered on posedge from the same selection (array value or bypassed write data).
  - Latency is 1 cycle. BYPASS=1 therefore gives read-after-write with zero bubble.
- BYPASS=0: a read in the cycle of a write to the same address returns the old value.
- Any number of read ports may share an address, with no interaction.
- Address range equals DEPTH exactly; no out-of-range case exists.

Test Plan (DEPTH=16, WIDTH=8, RPORT=4, WPORT=2, INIT_VAL=8'hA5):
- Reset release → init_done_o low for exactly 16 cycles, then high; all 16 addresses read 8'hA5; rdata_o=0 throughout CLEAR.
- READY, READ_REG=0: we=2'b01, waddr0=3, wdata0=8'h3C → next cycle raddr=3 gives 8'h3C; with BYPASS=1 the same-cycle read of 3 already gives 8'h3C, with BYPASS=0 it gives 8'hA5.
- Conflict: we=2'b11, both addresses 7, wdata0=8'h11, wdata1=8'h22 → ram[7]=8'h22; wr_conflict_o=1 for exactly one cycle; bypassed read of 7 in that cycle = 8'h22.
- READ_REG=1: write 8'h5A to address 9 with read port 2 at 9 the same cycle → rdata port 2 = 8'h5A one cycle later (BYPASS=1), or 8'hA5 (BYPASS=0).
- clear_i pulse in READY with a concurrent write of 8'hFF to address 0 → CLEAR runs 16 cycles, we_i ignored during it, then address 0 reads 8'hA5.
- Assert reset_n low at clr_idx=9 → init restarts; init_done_o rises exactly 16 cycles after reset release.

Source files
------------

// File: rtl/prf_ram_mp.sv
// Multi-port physical register file RAM with hardware initialisation,
// deterministic multi-write resolution and optional write-to-read bypass.
module prf_ram_mp #(
  parameter int              RPORT    = 8,
  parameter int              WPORT    = 4,
  parameter int              DEPTH    = 16,
  parameter int              INDEX    = 4,
  parameter int              WIDTH    = 8,
  parameter int              READ_REG = 0,
  parameter int              BYPASS   = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear_i,
  input  logic [RPORT*INDEX-1:0] raddr_i,
  output logic [RPORT*WIDTH-1:0] rdata_o,
  input  logic [WPORT*INDEX-1:0] waddr_i,
  input  logic [WPORT*WIDTH-1:0] wdata_i,
  input  logic [WPORT-1:0]       we_i,
  output logic                   init_done_o,
  output logic                   wr_conflict_o
);

  // state | meaning
  // CLEAR | sweeping INIT_VAL through every entry, user access blocked
  // READY | normal read/write operation
  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, state_nxt;
  logic [INDEX-1:0] clr_idx, clr_idx_nxt;
  logic [WIDTH-1:0] ram [DEPTH];
  logic             ready;
  logic             conflict_any;
  logic [RPORT*WIDTH-1:0] rsel;

  assign ready       = (state == READY);
  assign init_done_o = ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == INDEX'(DEPTH - 1)) state_nxt = READY;
      end
      READY: begin
        if (clear_i) begin
          state_nxt   = CLEAR;
          clr_idx_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Ascending port order with non-blocking updates lets the highest port win.
  always_ff @(posedge clk) begin
    if (!ready) begin
      ram[clr_idx] <= INIT_VAL;
    end else begin
      for (int w = 0; w < WPORT; w++) begin
        if (we_i[w]) ram[waddr_i[w*INDEX +: INDEX]] <= wdata_i[w*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    conflict_any = 1'b0;
    for (int i = 0; i < WPORT; i++) begin
      for (int j = i + 1; j < WPORT; j++) begin
        if (we_i[i] && we_i[j] &&
            (waddr_i[i*INDEX +: INDEX] == waddr_i[j*INDEX +: INDEX]))
          conflict_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_conflict_o <= 1'b0;
    else          wr_conflict_o <= ready & conflict_any;
  end

  // Read selection: array value, overridden by the highest matching write.
  always_comb begin
    rsel = '0;
    for (int p = 0; p < RPORT; p++) begin
      logic [INDEX-1:0] a;
      logic [WIDTH-1:0] v;
      a = raddr_i[p*INDEX +: INDEX];
      v = ram[a];
      if (BYPASS != 0) begin
        for (int w = 0; w < WPORT; w++) begin
          if (we_i[w] && (waddr_i[w*INDEX +: INDEX] == a)) v = wdata_i[w*WIDTH +: WIDTH];
        end
      end
      rsel[p*WIDTH +: WIDTH] = ready ? v : '0;
    end
  end

  generate
    if (READ_REG != 0) begin : g_rreg
      logic [RPORT*WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rsel;
      end
      assign rdata_o = rdata_q;
    end else begin : g_rcomb
      assign rdata_o = rsel;
    end
  endgenerate

endmodule

// File: tb/tb_prf_ram_mp.sv
// Bench for prf_ram_mp: a combinational-read/bypass instance and a
// registered-read/no-bypass instance share stimulus and are checked against a model.
module tb_prf_ram_mp;
  localparam logic [7:0] IV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_i = 1'b0;
  logic [15:0] raddr = '0;
  logic [7:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  we = '0;
  logic [31:0] rdata_c, rdata_r;
  logic        done_c, done_r, conf_c, conf_r;

  always #5 clk = ~clk;

  prf_ram_mp #(.RPORT(4), .WPORT(2), .DEPTH(16), .INDEX(4), .WIDTH(8),
               .READ_REG(0), .BYPASS(1), .INIT_VAL(IV)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .raddr_i(raddr),
    .rdata_o(rdata_c), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .init_done_o(done_c), .wr_conflict_o(conf_c));

  prf_ram_mp #(.RPORT(4), .WPORT(2), .DEPTH(16), .INDEX(4), .WIDTH(8),
               .READ_REG(1), .BYPASS(0), .INIT_VAL(IV)) dut_r (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .raddr_i(raddr),
    .rdata_o(rdata_r), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .init_done_o(done_r), .wr_conflict_o(conf_r));

  int checks = 0;
  int errors = 0;

  // Reference model: contents, ready flag, init sweep position, registered outputs.
  logic [7:0]  mem [16];
  bit          m_ready = 1'b0;
  int          m_clr = 0;
  logic        m_conf = 1'b0;
  logic [31:0] m_rreg = '0;

  function automatic logic [7:0] model_read(int p, bit byp);
    logic [3:0] a;
    logic [7:0] v;
    a = raddr[p*4 +: 4];
    if (!m_ready) return 8'h00;
    v = mem[a];
    if (byp) begin
      for (int w = 0; w < 2; w++)
        if (we[w] && (waddr[w*4 +: 4] == a)) v = wdata[w*8 +: 8];
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check pre-edge outputs, advance model at the edge, check post-edge outputs.
  task automatic cycle();
    logic [31:0] nxt_rreg;
    logic        nxt_conf;
    #1;
    check("init_done_c", {31'd0, done_c}, {31'd0, m_ready});
    check("init_done_r", {31'd0, done_r}, {31'd0, m_ready});
    for (int p = 0; p < 4; p++) begin
      check($sformatf("rdata_comb_p%0d", p), {24'd0, rdata_c[p*8 +: 8]}, {24'd0, model_read(p, 1'b1)});
      nxt_rreg[p*8 +: 8] = model_read(p, 1'b0);
    end
    nxt_conf = m_ready && (we == 2'b11) && (waddr[3:0] == waddr[7:4]);
    @(posedge clk);
    #1;
    if (!m_ready) begin
      mem[m_clr] = IV;
      m_clr++;
      if (m_clr == 16) m_ready = 1'b1;
    end else begin
      for (int w = 0; w < 2; w++)
        if (we[w]) mem[waddr[w*4 +: 4]] = wdata[w*8 +: 8];
      if (clear_i) begin
        m_ready = 1'b0;
        m_clr = 0;
      end
    end
    m_conf = nxt_conf;
    m_rreg = nxt_rreg;
    check("wr_conflict_c", {31'd0, conf_c}, {31'd0, m_conf});
    check("wr_conflict_r", {31'd0, conf_r}, {31'd0, m_conf});
    check("rdata_reg", rdata_r, m_rreg);
  endtask

  task automatic rand_in(input bit allow_clear);
    raddr = 16'($urandom);
    waddr = 8'($urandom);
    wdata = 16'($urandom);
    we    = 2'($urandom);
    if ($urandom_range(0, 3) == 0) waddr[7:4] = waddr[3:0];
    clear_i = allow_clear && ($urandom_range(0, 39) == 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    m_ready = 1'b0;
    m_clr = 0;
    m_conf = 1'b0;
    m_rreg = '0;
    check("rst_init_done", {31'd0, done_c}, 32'd0);
    check("rst_conflict", {31'd0, conf_r}, 32'd0);
    check("rst_rdata_reg", rdata_r, 32'd0);
    check("rst_rdata_comb", rdata_c, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Runs cycles until READY, returning how many clock edges it took (bounded).
  task automatic run_clear(output int n);
    n = 0;
    while (!done_c && n < 40) begin
      rand_in(1'b0);
      cycle();
      n++;
    end
  endtask

  initial begin
    int n;
    clear_i = 1'b0;
    rand_in(1'b0);
    apply_reset();
    run_clear(n);
    check("init_len", n, 32'd16);

    we = 2'b00;
    clear_i = 1'b0;
    for (int a = 0; a < 16; a += 4) begin
      raddr = {4'(a + 3), 4'(a + 2), 4'(a + 1), 4'(a)};
      #1;
      check("init_contents", rdata_c, {4{IV}});
      cycle();
    end

    we = 2'b01; waddr = {4'h0, 4'h3}; wdata = {8'h00, 8'h3C}; raddr = {4{4'h3}};
    #1;
    check("bypass_same_cycle", {24'd0, rdata_c[7:0]}, 32'h3C);
    cycle();
    check("nobypass_old", {24'd0, rdata_r[7:0]}, 32'hA5);
    we = 2'b00;
    cycle();
    check("raw_next_cycle", {24'd0, rdata_r[7:0]}, 32'h3C);

    we = 2'b11; waddr = {4'h7, 4'h7}; wdata = {8'h22, 8'h11}; raddr = {4{4'h7}};
    #1;
    check("conflict_bypass", {24'd0, rdata_c[7:0]}, 32'h22);
    cycle();
    check("conflict_flag", {31'd0, conf_c}, 32'd1);
    we = 2'b00;
    cycle();
    check("conflict_pulse_end", {31'd0, conf_c}, 32'd0);
    check("conflict_winner", {24'd0, rdata_c[7:0]}, 32'h22);

    we = 2'b01; waddr = {4'h0, 4'h9}; wdata = {8'h00, 8'h5A}; raddr = {4'h0, 4'h9, 4'h0, 4'h0};
    cycle();
    check("rreg_nobypass", {24'd0, rdata_r[23:16]}, 32'hA5);
    we = 2'b00;
    cycle();
    check("rreg_after_write", {24'd0, rdata_r[23:16]}, 32'h5A);

    for (int i = 0; i < 300; i++) begin
      rand_in(1'b1);
      cycle();
    end
    clear_i = 1'b0;
    run_clear(n);
    check("ready_after_random", {31'd0, done_c}, 32'd1);

    clear_i = 1'b1; we = 2'b01; waddr = {4'h0, 4'h0}; wdata = {8'h00, 8'hFF};
    cycle();
    clear_i = 1'b0;
    run_clear(n);
    check("clear_len", n, 32'd16);
    we = 2'b00; raddr = '0;
    #1;
    check("clear_addr0", {24'd0, rdata_c[7:0]}, 32'hA5);
    cycle();

    clear_i = 1'b1; we = 2'b00;
    cycle();
    clear_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_in(1'b0);
      cycle();
    end
    check("mid_clear_idx", m_clr, 32'd9);
    apply_reset();
    run_clear(n);
    check("reinit_len", n, 32'd16);
    for (int i = 0; i < 40; i++) begin
      rand_in(1'b1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
